bin_to_bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits between the countdown timer's binary count output and the per-digit 7-segment decoders.
- Converts one IN_WIDTH-bit binary value into DIGITS packed BCD nibbles, one bit per clock, using a start/ready/valid handshake.
- Holds the last result stable so the display decoders see clean decimal digits.

---
 rtl/bin_to_bcd_seq.sv | 99 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock into DIGITS packed BCD nibbles.
// Bcd/Overflow are loaded only on the final iteration, so the display never sees partial values.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [IN_WIDTH-1:0]   BinIn,
  output logic                  Ready,
  output logic                  Valid,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] bin_q, bin_nxt;
  logic [BCD_W-1:0]    scr_q, scr_nxt, scr_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                ovf_q, ovf_nxt;
  logic                carry_out;
  logic                load_out;

  // Digits are corrected independently; no carry crosses a nibble boundary.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign scr_adj = add3(scr_q);
  assign Ready   = (state == IDLE);

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf_q;
    carry_out = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          bin_nxt   = BinIn;
          scr_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = CNT_W'(IN_WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is the truncated high-order decimal part.
        {carry_out, scr_nxt, bin_nxt} = {scr_adj, bin_q, 1'b0};
        ovf_nxt = ovf_q | carry_out;
        cnt_nxt = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          load_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      Valid    <= 1'b0;
      Bcd      <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      bin_q <= bin_nxt;
      scr_q <= scr_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
      Valid <= load_out;
      if (load_out) begin
        Bcd      <= scr_nxt;
        Overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share all inputs.
module tb_bin_to_bcd_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  BinIn;
  logic        Ready, Valid, Overflow;
  logic [11:0] Bcd;
  logic        Ready2, Valid2, Overflow2;
  logic [7:0]  Bcd2;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BinIn(BinIn),
    .Ready(Ready), .Valid(Valid), .Bcd(Bcd), .Overflow(Overflow)
  );

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BinIn(BinIn),
    .Ready(Ready2), .Valid(Valid2), .Bcd(Bcd2), .Overflow(Overflow2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Wait (bounded) for Valid after an accepting edge; returns edges elapsed, 21 on timeout.
  task automatic wait_valid(output int n, output bit ready_bad);
    n = 21;
    ready_bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Valid) begin
        n = i;
        break;
      end
      if (Ready !== 1'b0) ready_bad = 1'b1;
    end
  endtask

  task automatic run_conv(input string tag, input logic [7:0] bin, input logic [11:0] exp_bcd,
                          input logic [7:0] exp_bcd2, input logic exp_ovf2);
    int  n;
    bit  rb;
    Start = 1'b1;
    BinIn = bin;
    tick();
    Start = 1'b0;
    chk({tag, "_ready_low"}, 32'(Ready), 32'd0);
    wait_valid(n, rb);
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_ready_during"}, 32'(rb), 32'd0);
    chk({tag, "_bcd"}, 32'(Bcd), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(Overflow), 32'd0);
    chk({tag, "_bcd2"}, 32'(Bcd2), 32'(exp_bcd2));
    chk({tag, "_ovf2"}, 32'(Overflow2), 32'(exp_ovf2));
    tick();
    chk({tag, "_valid_single"}, 32'(Valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(Ready), 32'd1);
    chk({tag, "_bcd_hold"}, 32'(Bcd), 32'(exp_bcd));
  endtask

  initial begin
    int n1, n2, vcount, vfirst;
    bit rb;
    Reset = 1'b0;
    Start = 1'b0;
    BinIn = '0;
    tick();
    tick();
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_bcd", 32'(Bcd), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    Reset = 1'b1;
    tick();

    run_conv("c120", 8'd120, 12'h120, 8'h20, 1'b1);
    run_conv("c0",   8'd0,   12'h000, 8'h00, 1'b0);
    run_conv("c255", 8'd255, 12'h255, 8'h55, 1'b1);

    // Back-to-back: Start held high, second value accepted in the Valid cycle.
    Start = 1'b1;
    BinIn = 8'd99;
    tick();
    BinIn = 8'd100;
    wait_valid(n1, rb);
    chk("b2b_lat1", 32'(n1), 32'd8);
    chk("b2b_bcd1", 32'(Bcd), 32'h099);
    tick();
    Start = 1'b0;
    chk("b2b_valid_gap", 32'(Valid), 32'd0);
    chk("b2b_ready_low", 32'(Ready), 32'd0);
    wait_valid(n2, rb);
    chk("b2b_spacing", 32'(n2 + 1), 32'd9);
    chk("b2b_bcd2", 32'(Bcd), 32'h100);
    tick();

    // Start re-pulse and BinIn change during SHIFT are ignored.
    Start = 1'b1;
    BinIn = 8'd45;
    tick();
    Start = 1'b0;
    vcount = 0;
    vfirst = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) begin
        Start = 1'b1;
        BinIn = 8'd7;
      end
      if (i == 4) Start = 1'b0;
      if (Valid) begin
        vcount++;
        if (vfirst == 0) vfirst = i;
      end
    end
    chk("ign_valid_count", 32'(vcount), 32'd1);
    chk("ign_latency", 32'(vfirst), 32'd8);
    chk("ign_bcd", 32'(Bcd), 32'h045);

    // Asynchronous reset in the middle of converting 200.
    Start = 1'b1;
    BinIn = 8'd200;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(Bcd), 32'd0);
    chk("mid_rst_ready", 32'(Ready), 32'd1);
    chk("mid_rst_ovf2", 32'(Overflow2), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Valid) vcount++;
    end
    chk("mid_rst_no_valid", 32'(vcount), 32'd0);
    chk("mid_rst_bcd_hold", 32'(Bcd), 32'd0);
    run_conv("c200", 8'd200, 12'h200, 8'h00, 1'b1);

    // Two-digit instance: overflow sets, then clears on the next conversion.
    run_conv("d2_255", 8'd255, 12'h255, 8'h55, 1'b1);
    run_conv("d2_42",  8'd42,  12'h042, 8'h42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
